// File: rtl/p2_link_controller.sv
// rtl/p2_link_controller.sv - player-2 button link: slave frame transmitter and master frame receiver
module p2_link_controller #(
    parameter int BIT_TICKS      = 1000,
    parameter int FRAME_GAP_BITS = 2,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       isMaster,
    input  logic [4:0] btn_in,
    input  logic       link_rx,
    output logic       link_tx,
    output logic [4:0] btn_out,
    output logic       link_ok,
    output logic       frame_err
);
    localparam int TICK_W   = $clog2(BIT_TICKS);
    localparam int BIT_MAX  = (FRAME_GAP_BITS > 5) ? FRAME_GAP_BITS : 5;
    localparam int BIT_W    = $clog2(BIT_MAX + 1);
    localparam int TO_LIMIT = TIMEOUT_FRAMES * (8 + FRAME_GAP_BITS) * BIT_TICKS;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(BIT_TICKS / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(4);
    localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'(FRAME_GAP_BITS - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TO_LIMIT);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_GAP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

    txState_t          txState, txNext;
    rxState_t          rxState, rxNext;
    logic [TICK_W-1:0] txTick, rxTick;
    logic [BIT_W-1:0]  txBit, txBitNext;
    logic [2:0]        rxBit;
    logic [4:0]        txData, rxData;
    logic              rxPar, txLevel;
    logic              rxSync1, rxSync2, rxPrev;
    logic [TO_W-1:0]   toCnt;
    logic              prevMaster, roleChange, txHold, rxHold;
    logic              txBitEnd, rxHalf, rxFull, rxFall;
    logic              frameDone, frameGood, frameBad;

    // Any role edge parks both FSMs for one cycle so a half-received frame is dropped.
    assign roleChange = isMaster ^ prevMaster;
    assign txHold     = isMaster | roleChange;
    assign rxHold     = ~isMaster | roleChange;
    assign txBitEnd   = (txTick == TICK_LAST);
    assign rxHalf     = (rxTick == TICK_HALF);
    assign rxFull     = (rxTick == TICK_LAST);
    assign rxFall     = rxPrev & ~rxSync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txState <= TX_IDLE;
            rxState <= RX_IDLE;
        end else begin
            txState <= txNext;
            rxState <= rxNext;
        end
    end

    always_comb begin
        txNext    = txState;
        txBitNext = txBit;
        if (txHold) begin
            txNext    = TX_IDLE;
            txBitNext = '0;
        end else begin
            case (txState)
                TX_IDLE: begin
                    txNext    = TX_START;
                    txBitNext = '0;
                end
                TX_START: if (txBitEnd) begin
                    txNext    = TX_DATA;
                    txBitNext = '0;
                end
                TX_DATA: if (txBitEnd) begin
                    if (txBit == DATA_LAST) begin
                        txNext    = TX_PARITY;
                        txBitNext = '0;
                    end else begin
                        txBitNext = txBit + 1'b1;
                    end
                end
                TX_PARITY: if (txBitEnd) txNext = TX_STOP;
                TX_STOP: if (txBitEnd) begin
                    txNext    = (FRAME_GAP_BITS > 0) ? TX_GAP : TX_START;
                    txBitNext = '0;
                end
                TX_GAP: if (txBitEnd) begin
                    if (txBit == GAP_LAST) begin
                        txNext    = TX_START;
                        txBitNext = '0;
                    end else begin
                        txBitNext = txBit + 1'b1;
                    end
                end
                default: txNext = TX_IDLE;
            endcase
        end
    end

    // Line level follows the state being entered so link_tx lines up with the state register.
    always_comb begin
        case (txNext)
            TX_START:  txLevel = 1'b0;
            TX_DATA:   txLevel = txData[txBitNext[2:0]];
            TX_PARITY: txLevel = ^txData;
            default:   txLevel = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txBit   <= '0;
            txTick  <= '0;
            txData  <= '0;
            link_tx <= 1'b1;
        end else begin
            txBit   <= txBitNext;
            txTick  <= (txHold || txState == TX_IDLE || txBitEnd) ? '0 : txTick + 1'b1;
            if (txNext == TX_START && txState != TX_START) txData <= btn_in;
            link_tx <= txLevel;
        end
    end

    always_comb begin
        rxNext = rxState;
        if (rxHold) begin
            rxNext = RX_IDLE;
        end else begin
            case (rxState)
                RX_IDLE:   if (rxFall) rxNext = RX_START;
                RX_START:  if (rxHalf) rxNext = rxSync2 ? RX_IDLE : RX_DATA;
                RX_DATA:   if (rxFull && rxBit == 3'd4) rxNext = RX_PARITY;
                RX_PARITY: if (rxFull) rxNext = RX_STOP;
                RX_STOP:   if (rxFull) rxNext = RX_IDLE;
                default:   rxNext = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        frameDone = !rxHold && rxState == RX_STOP && rxFull;
        frameGood = frameDone && rxSync2 && ((^rxData) == rxPar);
        frameBad  = frameDone && !frameGood;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxSync1    <= 1'b1;
            rxSync2    <= 1'b1;
            rxPrev     <= 1'b1;
            rxTick     <= '0;
            rxBit      <= '0;
            rxData     <= '0;
            rxPar      <= 1'b0;
            prevMaster <= 1'b0;
        end else begin
            rxSync1    <= link_rx;
            rxSync2    <= rxSync1;
            rxPrev     <= rxSync2;
            prevMaster <= isMaster;
            rxTick     <= (rxHold || rxState == RX_IDLE || rxNext != rxState || rxFull) ? '0 : rxTick + 1'b1;
            if (rxHold || rxState != RX_DATA) rxBit <= '0;
            else if (rxFull) rxBit <= rxBit + 1'b1;
            if (rxState == RX_DATA && rxFull) rxData <= {rxSync2, rxData[4:1]};
            if (rxState == RX_PARITY && rxFull) rxPar <= rxSync2;
        end
    end

    // A good frame wins over a timeout expiring in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_out   <= '0;
            link_ok   <= 1'b0;
            frame_err <= 1'b0;
            toCnt     <= '0;
        end else begin
            frame_err <= frameBad;
            if (rxHold) begin
                btn_out <= '0;
                link_ok <= 1'b0;
                toCnt   <= '0;
            end else if (frameGood) begin
                btn_out <= rxData;
                link_ok <= 1'b1;
                toCnt   <= '0;
            end else if (toCnt != TO_MAX) begin
                toCnt <= toCnt + 1'b1;
                if (toCnt == TO_LAST) begin
                    btn_out <= '0;
                    link_ok <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/p2_link_controller.md
# p2_link_controller

Sequences the inter-board serial link carrying player-2 button state from the slave board to the master board. On the slave it continuously frames and transmits the local 5-button vector. On the master it receives and validates frames, then presents a held, debounced-by-frame button vector to the game core. It sits between the board's button/role logic and the single-wire link pin, replacing parallel per-button wires with one framed serial line.

## Interface
- BIT_TICKS, 1000, clk cycles per link bit (100 kbit/s at 100 MHz); must be even and ≥ 8
- FRAME_GAP_BITS, 2, idle-high bit times inserted between transmitted frames
- TIMEOUT_FRAMES, 8, frame periods without a valid frame before the master drops the link
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- isMaster  in  1  role select: 1 = receive (master), 0 = transmit (slave)
- btn_in  in  5  slave local buttons {attack, right, left, down, up}, bit 0 = up
- link_rx  in  1  serial link input, asynchronous to clk
- link_tx  out  1  serial link output, idles high
- btn_out  out  5  master's received button vector, same bit order as btn_in
- link_ok  out  1  master has received a valid frame within the timeout window
- frame_err  out  1  one-cycle pulse on a rejected frame (parity or stop error)

## Operation
- Frame: start (0), 5 data bits LSB first, even parity over the data bits, stop (1); 8 bit times in total. Frame period = (8 + FRAME_GAP_BITS) × BIT_TICKS.
- Slave TX FSM (isMaster = 0): IDLE → START → DATA(×5) → PARITY → STOP → GAP → START … Transmits continuously. btn_in is captured into a shift register on the cycle the FSM enters START. Each state holds its bit for exactly BIT_TICKS cycles. GAP drives 1 for FRAME_GAP_BITS bit times. link_tx is registered.
- Master RX FSM (isMaster = 1): link_rx passes through a 2-flop synchronizer.
  - IDLE: wait for a synchronized 1→0 edge.
  - START: at BIT_TICKS/2, re-sample. If low, proceed; else return to IDLE (glitch reject).
  - DATA, PARITY, STOP: sample at each following bit centre (every BIT_TICKS).
  - STOP, sample = 1 and parity good: btn_out ← data, link_ok ← 1, timeout counter cleared.
  - STOP, any error: frame_err pulses, btn_out holds.
  - Either outcome returns to IDLE.
- Master mode forces link_tx = 1. Slave mode forces btn_out = 0, link_ok = 0, frame_err = 0, and the RX FSM to IDLE.
- Timeout: the master counts cycles since the last valid frame. At TIMEOUT_FRAMES × frame period it sets btn_out ← 0 and link_ok ← 0. The counter saturates there; it does not wrap.
- Role change: any isMaster transition synchronously returns both FSMs to IDLE/START-pending. It also clears btn_out, link_ok, bit counters and the timeout counter in the cycle after the change. A frame in flight is discarded, not half-applied.

## Timing
- Reset values: link_tx = 1, btn_out = 0, link_ok = 0, frame_err = 0; all FSMs IDLE, all counters 0.
- Slave: the first START begins 1 cycle after rst_n deasserts (IDLE lasts 1 cycle).
- Master: btn_out/link_ok update 1 cycle after the stop-bit centre sample. frame_err is high for exactly that one cycle.
- End-to-end latency from slave START entry to master btn_out update: 7.5 × BIT_TICKS + 4 cycles, ±1 cycle.
- Edge cases:
  - btn_in changing mid-frame has no effect until the next START capture.
  - A valid frame completing on the same cycle the timeout expires takes priority: the data is applied and link_ok stays 1.

## Test plan
- Loopback (slave TX → master RX, BIT_TICKS = 16), btn_in = 5'b10110 → btn_out = 5'b10110 and link_ok = 1 after the first frame; frame_err never pulses.
- Parity error: inject a frame with data 5'b00001 and parity 0 → frame_err single-cycle pulse, btn_out holds its previous value, link_ok unchanged.
- Glitch: 3-cycle low pulse on idle link_rx → RX returns to IDLE, no btn_out change, no frame_err.
- Link loss: after a valid frame (btn_out = 5'b00100), hold link_rx high for TIMEOUT_FRAMES × 10 × 16 cycles → btn_out = 0 and link_ok = 0 exactly at expiry.
- Role switch mid-receive: toggle isMaster to 0 during DATA → next cycle btn_out = 0, link_ok = 0, link_tx starts a START bit; switch back → reception resumes on the next frame.
- Async reset asserted mid-frame in both roles → all outputs at reset values immediately; the slave restarts with START 1 cycle after release.
